// File: rtl/fifo_uart_tx.sv
// FIFO-to-UART transmitter: pops one word at a time from a FIFO read port and
// sends it as a start bit, DATA_W data bits (LSB first) and a stop bit.
module fifo_uart_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_en_o,
    input  logic [DATA_W-1:0] fifo_rd_data_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              frame_done_o
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE_LAST = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST      = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              state_q;
    logic [BAUD_W-1:0]   baud_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   shift_d;
    logic                tx_q;
    logic                rd_en_q;
    logic                busy_q;
    logic                frame_done_q;
    logic                baud_wrap;
    logic                can_pop;

    assign shift_d   = shift_q >> 1;
    assign baud_wrap = (baud_q == BAUD_LAST);
    assign can_pop   = enable_i && !fifo_empty_i;

    // Outputs are driven from registers set one state ahead, so tx changes on
    // the same edge the state does and nothing combinational reaches a pin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            rd_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (can_pop) begin
                        state_q <= S_POP;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_POP: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    shift_q <= fifo_rd_data_i;
                    tx_q    <= 1'b0;
                    baud_q  <= '0;
                    state_q <= S_START;
                end
                S_START: begin
                    if (baud_wrap) begin
                        baud_q    <= '0;
                        bit_cnt_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_wrap) begin
                        baud_q <= '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
                            tx_q      <= 1'b1;
                            state_q   <= S_STOP;
                        end else begin
                            shift_q   <= shift_d;
                            tx_q      <= shift_d[0];
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud_wrap) begin
                        baud_q <= '0;
                        // Chain straight into the next pop so frames abut with only POP+LOAD between.
                        if (can_pop) begin
                            state_q <= S_POP;
                            rd_en_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                        if (baud_q == BAUD_PRE_LAST) begin
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en_o = rd_en_q;
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;

endmodule
